// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl_pkg
// Brief   : ISA field accessors, opcode/aluop constants and FSM state type
//           shared by the pipeline control block.
// Revision: 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    localparam logic [4:0]  c_op_rtype  = 5'b00000;
    localparam logic [4:0]  c_op_bne    = 5'b00010;
    localparam logic [4:0]  c_op_jr     = 5'b00100;
    localparam logic [4:0]  c_op_addi   = 5'b00101;
    localparam logic [4:0]  c_op_blt    = 5'b00110;
    localparam logic [4:0]  c_op_sw     = 5'b00111;
    localparam logic [4:0]  c_op_lw     = 5'b01000;
    localparam logic [4:0]  c_op_bex    = 5'b10110;
    localparam logic [4:0]  c_alu_mult  = 5'b00110;
    localparam logic [4:0]  c_alu_div   = 5'b00111;
    localparam logic [4:0]  c_reg_zero  = 5'd0;
    localparam logic [4:0]  c_reg_stat  = 5'd30;
    localparam logic [31:0] c_nop_word  = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    function automatic logic [4:0] f_opcode(input logic [31:0] insn);
        return insn[31:27];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] insn);
        return insn[26:22];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] insn);
        return insn[21:17];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] insn);
        return insn[16:12];
    endfunction

    function automatic logic [4:0] f_aluop(input logic [31:0] insn);
        return insn[6:2];
    endfunction

    function automatic logic f_is_md(input logic [31:0] insn);
        return (f_opcode(insn) == c_op_rtype) &&
               ((f_aluop(insn) == c_alu_mult) || (f_aluop(insn) == c_alu_div));
    endfunction

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module  : hazard_detect
// Brief   : Flags a load-use hazard between the lw in D/X and the F/D insn.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [31:0] i_fd_insn,
    input  logic [31:0] i_dx_insn,
    output logic        o_load_use
);

    logic [4:0] w_dst;
    logic       w_hit_rs;
    logic       w_hit_rt;
    logic       w_hit_rd;
    logic       w_reads_dst;

    assign w_dst    = f_rd(i_dx_insn);
    assign w_hit_rs = (f_rs(i_fd_insn) == w_dst);
    assign w_hit_rt = (f_rt(i_fd_insn) == w_dst);
    assign w_hit_rd = (f_rd(i_fd_insn) == w_dst);

    always_comb begin
        w_reads_dst = 1'b0;
        case (f_opcode(i_fd_insn))
            c_op_rtype:                   w_reads_dst = w_hit_rs | w_hit_rt;
            c_op_addi, c_op_lw:           w_reads_dst = w_hit_rs;
            c_op_sw, c_op_bne, c_op_blt:  w_reads_dst = w_hit_rs | w_hit_rd;
            c_op_jr:                      w_reads_dst = w_hit_rd;
            c_op_bex:                     w_reads_dst = (w_dst == c_reg_stat);
            default:                      w_reads_dst = 1'b0;
        endcase
    end

    assign o_load_use = (f_opcode(i_dx_insn) == c_op_lw) &&
                        (w_dst != c_reg_zero) && w_reads_dst;

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl
// Brief   : Pipe-register enable/bubble sequencer resolving load-use stalls,
//           taken-branch squash and multi-cycle mult/div holds.
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fd_insn,
    input  logic [31:0] dx_insn,
    input  logic        branch_taken,
    input  logic        md_ready,
    input  logic        md_exception,
    output logic        pc_we,
    output logic        fd_we,
    output logic        dx_we,
    output logic        xm_we,
    output logic        mw_we,
    output logic        fd_flush,
    output logic        dx_flush,
    output logic        xm_flush,
    output logic        md_start,
    output logic        md_is_div,
    output logic        md_timeout,
    output logic        busy
);

    localparam int                 c_cnt_w    = $clog2(MD_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MD_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(MD_TIMEOUT);

    state_t             r_state;
    state_t             w_next_state;
    logic [c_cnt_w-1:0] r_count;
    logic               r_dx_fresh;
    logic               w_load_use;
    logic               w_unused;

    // Overflow capture is a datapath concern; the controller only sequences.
    assign w_unused = md_exception;

    hazard_detect u_hazard_detect (
        .i_fd_insn  (fd_insn),
        .i_dx_insn  (dx_insn),
        .o_load_use (w_load_use)
    );

    always_comb begin
        pc_we        = 1'b0;
        fd_we        = 1'b0;
        dx_we        = 1'b0;
        xm_we        = 1'b0;
        mw_we        = 1'b0;
        fd_flush     = 1'b0;
        dx_flush     = 1'b0;
        xm_flush     = 1'b0;
        md_start     = 1'b0;
        md_is_div    = 1'b0;
        md_timeout   = 1'b0;
        w_next_state = r_state;
        if (reset) begin
            case (r_state)
                ST_RUN: begin
                    // r_dx_fresh blocks a restart on a mult/div left in D/X across reset.
                    if (f_is_md(dx_insn) && r_dx_fresh) begin
                        md_start     = 1'b1;
                        md_is_div    = f_aluop(dx_insn) == c_alu_div;
                        xm_we        = 1'b1;
                        mw_we        = 1'b1;
                        xm_flush     = 1'b1;
                        w_next_state = ST_MD_BUSY;
                    end else if (branch_taken) begin
                        {pc_we, fd_we, dx_we, xm_we, mw_we} = 5'b11111;
                        fd_flush = 1'b1;
                        dx_flush = 1'b1;
                    end else if (w_load_use) begin
                        {dx_we, xm_we, mw_we} = 3'b111;
                        dx_flush = 1'b1;
                    end else begin
                        {pc_we, fd_we, dx_we, xm_we, mw_we} = 5'b11111;
                    end
                end
                ST_MD_BUSY: begin
                    xm_we = 1'b1;
                    mw_we = 1'b1;
                    if (md_ready || (r_count == c_cnt_last)) begin
                        {pc_we, fd_we, dx_we} = 3'b111;
                        md_timeout   = !md_ready;
                        w_next_state = ST_RUN;
                    end else begin
                        xm_flush = 1'b1;
                    end
                end
                default: w_next_state = ST_RUN;
            endcase
        end
    end

    assign busy = reset && (r_state != ST_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_count    <= '0;
            r_dx_fresh <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_dx_fresh <= dx_we;
            if (r_state == ST_RUN) begin
                r_count <= '0;
            end else if (r_count != c_cnt_max) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_ctrl
// Brief   : Self-checking bench: directed hazard scenarios plus random traffic
//           compared every cycle against a behavioural pipeline-control model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int C_TO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] fd_insn = 32'h0;
    logic [31:0] dx_insn = 32'h0;
    logic        branch_taken = 1'b0;
    logic        md_ready = 1'b0;
    logic        md_exception = 1'b0;
    logic pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_flush, xm_flush;
    logic md_start, md_is_div, md_timeout, busy;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_ctrl #(.MD_TIMEOUT(C_TO)) dut (
        .clk(clk), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn),
        .branch_taken(branch_taken), .md_ready(md_ready), .md_exception(md_exception),
        .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we), .xm_we(xm_we), .mw_we(mw_we),
        .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
        .md_start(md_start), .md_is_div(md_is_div), .md_timeout(md_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input logic [4:0] alu, input int rd, input int rs, input int rt);
        return {5'b00000, 5'(rd), 5'(rs), 5'(rt), 5'b0, alu, 2'b0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [4:0] op, input int rd, input int rs);
        return {op, 5'(rd), 5'(rs), 17'h0_0abc};
    endfunction

    function automatic bit is_md(input logic [31:0] w);
        return w[31:27] == 5'd0 && (w[6:2] == 5'd6 || w[6:2] == 5'd7);
    endfunction

    // Registers the F/D instruction reads, listed from the ISA table.
    function automatic bit stalls(input logic [31:0] fd, input logic [31:0] dx);
        int srcs[$];
        int dst;
        dst = int'(dx[26:22]);
        if (dx[31:27] != 5'd8 || dst == 0) return 0;
        case (int'(fd[31:27]))
            0:       begin srcs.push_back(int'(fd[21:17])); srcs.push_back(int'(fd[16:12])); end
            5, 8:    srcs.push_back(int'(fd[21:17]));
            2, 6, 7: begin srcs.push_back(int'(fd[21:17])); srcs.push_back(int'(fd[26:22])); end
            4:       srcs.push_back(int'(fd[26:22]));
            22:      srcs.push_back(30);
            default: ;
        endcase
        foreach (srcs[i]) if (srcs[i] == dst) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit m_in_md = 0;      // a mult/div is occupying X
    int m_md_cyc = 0;     // busy cycles already completed for that mult/div
    bit m_fresh = 0;      // D/X was loaded on the previous clock
    bit n_in_md = 0;
    int n_md_cyc = 0;
    bit n_fresh = 0;

    always @(negedge clk) begin
        logic [10:0] e, a;
        logic [4:0]  we;
        logic        fdf, dxf, xmf, st, to, bz, dv;
        we = 5'b0; fdf = 0; dxf = 0; xmf = 0; st = 0; to = 0; bz = 0; dv = 0;
        n_in_md = 0; n_md_cyc = 0; n_fresh = 0;
        if (reset) begin
            n_in_md = m_in_md;
            if (m_in_md) begin
                bit fin;
                bz = 1;
                fin = md_ready || (m_md_cyc + 1 == C_TO);
                we = fin ? 5'b11111 : 5'b00011;
                xmf = !fin;
                to = fin && !md_ready;
                n_in_md = !fin;
                n_md_cyc = m_md_cyc + 1;
            end else if (is_md(dx_insn) && m_fresh) begin
                st = 1; dv = dx_insn[2]; we = 5'b00011; xmf = 1;
                n_in_md = 1; n_md_cyc = 0;
            end else if (branch_taken) begin
                we = 5'b11111; fdf = 1; dxf = 1;
            end else if (stalls(fd_insn, dx_insn)) begin
                we = 5'b00111; dxf = 1;
            end else begin
                we = 5'b11111;
            end
            n_fresh = we[2];
        end
        e = {we, fdf, dxf, xmf, st, to, bz};
        a = {pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_flush, xm_flush, md_start, md_timeout, busy};
        chk("model_outputs", 32'(a), 32'(e));
        if (st) chk("model_md_is_div", 32'(md_is_div), 32'(dv));
    end

    always @(posedge clk) begin
        if (reset) begin
            m_in_md = n_in_md; m_md_cyc = n_md_cyc; m_fresh = n_fresh;
        end else begin
            m_in_md = 0; m_md_cyc = 0; m_fresh = 0;
        end
    end

    always @(negedge reset) begin
        m_in_md = 0; m_md_cyc = 0; m_fresh = 0;
    end

    // ---------------- stimulus ----------------
    task automatic tick();   @(posedge clk); #1; endtask
    task automatic sample(); @(negedge clk); #1; endtask

    task automatic set_in(input logic [31:0] fd, input logic [31:0] dx, input logic bt, input logic rdy);
        fd_insn = fd; dx_insn = dx; branch_taken = bt; md_ready = rdy;
        md_exception = 1'($urandom_range(0, 1));
    endtask

    logic [31:0] add_r5;
    int          n_busy, n_start, to_at;

    initial begin
        add_r5 = mk_r(5'd0, 1, 5, 2);
        tick();
        // Reset held low for three cycles
        for (int i = 0; i < 3; i++) begin
            set_in(add_r5, mk_i(5'd8, 5, 3), 1'b1, 1'b1);
            sample();
            chk("reset_outputs", 32'({pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_flush,
                                      xm_flush, md_start, md_timeout, busy}), 32'h0);
            tick();
        end
        reset = 1'b1;
        set_in(32'h0, 32'h0, 1'b0, 1'b0);
        sample();
        chk("release_all_we", 32'({pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_flush, xm_flush}), 32'hf8);
        tick();

        // Load-use: lw r5 in D/X, add r1,r5,r2 in F/D
        set_in(add_r5, mk_i(5'd8, 5, 3), 1'b0, 1'b0);
        sample();
        chk("loaduse_stall", 32'({pc_we, fd_we, dx_we, dx_flush}), 32'h3);
        tick();
        set_in(add_r5, 32'h0, 1'b0, 1'b0);
        sample();
        chk("loaduse_one_cycle", 32'({pc_we, fd_we, dx_we, dx_flush}), 32'he);
        tick();
        set_in(mk_r(5'd0, 1, 0, 2), mk_i(5'd8, 0, 3), 1'b0, 1'b0);
        sample();
        chk("loaduse_r0_no_stall", 32'({pc_we, fd_we, dx_flush}), 32'h6);
        tick();

        // Taken branch squashes two younger insns for one cycle
        set_in(add_r5, 32'h0, 1'b1, 1'b0);
        sample();
        chk("branch_squash", 32'({pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_flush}), 32'h7f);
        tick();
        set_in(add_r5, 32'h0, 1'b0, 1'b0);
        sample();
        chk("branch_one_cycle", 32'({fd_flush, dx_flush}), 32'h0);
        tick();

        // mult completing on the 32nd busy cycle
        set_in(32'h0, mk_r(5'd6, 3, 1, 2), 1'b0, 1'b0);
        sample();
        chk("mult_start", 32'({md_start, md_is_div, busy, xm_flush, dx_we}), 32'h12);
        n_start = int'(md_start);
        n_busy = 0;
        tick();
        for (int i = 1; i <= 32; i++) begin
            set_in(32'h0, mk_r(5'd6, 3, 1, 2), 1'b1, i == 32);
            sample();
            n_busy += int'(busy);
            n_start += int'(md_start);
            if (i == 31) chk("mult_hold", 32'({pc_we, fd_we, dx_we, xm_we, xm_flush}), 32'h3);
            if (i == 32) chk("mult_ready", 32'({pc_we, fd_we, dx_we, xm_we, xm_flush}), 32'h1e);
            tick();
        end
        chk("mult_busy_cycles", 32'(n_busy), 32'd32);
        chk("mult_start_pulses", 32'(n_start), 32'd1);
        set_in(32'h0, 32'h0, 1'b0, 1'b0);
        sample();
        chk("mult_back_run", 32'({busy, md_start}), 32'h0);
        tick();

        // div never completes: forced abort on the 64th busy cycle
        set_in(32'h0, mk_r(5'd7, 3, 1, 2), 1'b0, 1'b0);
        sample();
        chk("div_start", 32'({md_start, md_is_div}), 32'h3);
        tick();
        to_at = -1;
        for (int i = 1; i <= 70 && to_at < 0; i++) begin
            set_in(32'h0, mk_r(5'd7, 3, 1, 2), 1'b0, 1'b0);
            sample();
            if (md_timeout) to_at = i;
            tick();
        end
        chk("div_timeout_cycle", 32'(to_at), 32'd64);
        set_in(32'h0, 32'h0, 1'b0, 1'b0);
        sample();
        chk("div_timeout_pulse", 32'({md_timeout, busy}), 32'h0);
        tick();
        // md_ready on the same cycle as the timeout: ready wins
        set_in(32'h0, mk_r(5'd7, 3, 1, 2), 1'b0, 1'b0);
        tick();
        to_at = 0;
        for (int i = 1; i <= 64; i++) begin
            set_in(32'h0, mk_r(5'd7, 3, 1, 2), 1'b0, i == 64);
            sample();
            to_at += int'(md_timeout);
            tick();
        end
        chk("div_ready_beats_timeout", 32'(to_at), 32'd0);

        // Reset pulsed during MD_BUSY
        set_in(32'h0, mk_r(5'd6, 4, 1, 2), 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin set_in(32'h0, mk_r(5'd6, 4, 1, 2), 1'b0, 1'b0); tick(); end
        #2 reset = 1'b0;
        #1 chk("reset_busy_drop", 32'(busy), 32'h0);
        tick();
        reset = 1'b1;
        sample();
        chk("no_restart_after_reset", 32'({md_start, busy}), 32'h0);
        tick();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] fd, dx;
            int k;
            k = int'($urandom_range(0, 9));
            case (k)
                0, 1: fd = mk_r(5'($urandom_range(0, 7)), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
                2: fd = mk_i(5'd5, $urandom_range(0, 7), $urandom_range(0, 7));
                3: fd = mk_i(5'd8, $urandom_range(0, 7), $urandom_range(0, 7));
                4: fd = mk_i(5'd7, $urandom_range(0, 7), $urandom_range(0, 7));
                5: fd = mk_i(5'd2, $urandom_range(0, 7), $urandom_range(0, 7));
                6: fd = mk_i(5'd6, $urandom_range(0, 7), $urandom_range(0, 7));
                7: fd = mk_i(5'd4, $urandom_range(0, 7), $urandom_range(0, 7));
                8: fd = mk_i(5'd22, 0, 0);
                default: fd = mk_i(5'd1, 0, 0);
            endcase
            k = int'($urandom_range(0, 9));
            if (k < 4)      dx = mk_i(5'd8, (k == 0) ? 30 : int'($urandom_range(0, 7)), $urandom_range(0, 7));
            else if (k < 5) dx = mk_r(5'($urandom_range(6, 7)), $urandom_range(0, 7), 1, 2);
            else            dx = mk_r(5'($urandom_range(0, 3)), $urandom_range(0, 7), 1, 2);
            set_in(fd, dx, $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0);
            reset = ($urandom_range(0, 299) != 0);
            tick();
        end
        reset = 1'b1;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipeline_ctrl
`default_nettype wire
